// File: rtl/program_counter_unit_pkg.sv
// Shared constants for the program counter unit: update-op and phase-FSM encodings.
package program_counter_unit_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    PC_NEXT     = 2'b00,
    PC_JUMP_ABS = 2'b01,
    PC_JUMP_REL = 2'b10,
    PC_HOLD     = 2'b11
  } pc_op_e;

  typedef enum logic [1:0] {
    WAIT_F = 2'd0,
    WAIT_D = 2'd1,
    WAIT_E = 2'd2,
    WAIT_C = 2'd3
  } phase_e;

  // Operands captured at EXECUTE and consumed at COMMIT.
  typedef struct packed {
    pc_op_e          op;
    logic            cond;
    logic [PC_W-1:0] target;
  } lat_op_t;

  // Strobe pattern {commit, execute, decode, fetch} that legally advances each state.
  function automatic logic [3:0] phase_strobe(input phase_e s);
    case (s)
      WAIT_F:  phase_strobe = 4'b0001;
      WAIT_D:  phase_strobe = 4'b0010;
      WAIT_E:  phase_strobe = 4'b0100;
      default: phase_strobe = 4'b1000;
    endcase
  endfunction

endpackage

// File: rtl/program_counter_unit_phase_sequence_checker.sv
// Phase-order tracker: F -> D -> E -> C; flags out-of-order or overlapping strobes (sticky).
module phase_sequence_checker
  import program_counter_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic fetch,
  input  logic decode,
  input  logic execute,
  input  logic commit,
  input  logic stopped,
  output logic exec_ok,
  output logic commit_ok,
  output logic commit_seen,
  output logic seq_err
);

  phase_e     state_q, state_d;
  logic [3:0] strobes;
  logic       err;

  // A stopped decoder is treated as emitting no strobes at all.
  assign strobes     = stopped ? 4'b0000 : {commit, execute, decode, fetch};
  assign commit_seen = strobes[3];

  always_comb begin
    state_d   = state_q;
    exec_ok   = 1'b0;
    commit_ok = 1'b0;
    err       = 1'b0;
    if (strobes != 4'b0000) begin
      if (strobes != phase_strobe(state_q)) begin
        err     = 1'b1;
        state_d = WAIT_F;
      end else begin
        case (state_q)
          WAIT_F:  state_d = WAIT_D;
          WAIT_D:  state_d = WAIT_E;
          WAIT_E:  begin state_d = WAIT_C; exec_ok = 1'b1; end
          default: begin state_d = WAIT_F; commit_ok = 1'b1; end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_F;
      seq_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err) seq_err <= 1'b1;
    end
  end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter datapath: latches the op at EXECUTE, applies NEXT/jump at COMMIT.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch,
  input  logic            decode,
  input  logic            execute,
  input  logic            commit,
  input  logic            stopped,
  input  logic            pc_enx,
  input  logic [1:0]      pc_op,
  input  logic            cond,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link,
  output logic            taken,
  output logic            seq_err
);

  logic            exec_ok, commit_ok, commit_seen;
  lat_op_t         lat;
  logic [PC_W-1:0] pc_inc, pc_jmp, pc_nxt;
  logic            jump;

  phase_sequence_checker u_seq (
    .clk         (clk),
    .reset       (reset),
    .fetch       (fetch),
    .decode      (decode),
    .execute     (execute),
    .commit      (commit),
    .stopped     (stopped),
    .exec_ok     (exec_ok),
    .commit_ok   (commit_ok),
    .commit_seen (commit_seen),
    .seq_err     (seq_err)
  );

  assign pc_inc = pc + 16'd1;

  // A jump with a false condition degrades to NEXT.
  always_comb begin
    jump   = 1'b0;
    pc_jmp = pc_inc;
    case (lat.op)
      PC_JUMP_ABS: begin jump = lat.cond; pc_jmp = lat.target; end
      PC_JUMP_REL: begin jump = lat.cond; pc_jmp = pc + lat.target; end
      default:     ;
    endcase
    pc_nxt = jump ? pc_jmp : pc_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_VECTOR;
      link  <= '0;
      taken <= 1'b0;
      lat   <= '{op: PC_HOLD, cond: 1'b0, target: '0};
    end else begin
      taken <= 1'b0;
      if (exec_ok) lat <= '{op: pc_op_e'(pc_op), cond: cond, target: target};
      // Consume the op on any commit so a stray repeat cannot re-apply it.
      if (commit_seen) lat.op <= PC_HOLD;
      if (commit_ok && pc_enx && lat.op != PC_HOLD) begin
        pc    <= pc_nxt;
        link  <= pc_inc;
        taken <= jump;
      end
    end
  end

endmodule

// File: tb/tb_program_counter_unit.sv
// Bench for program_counter_unit: instruction table plus hand-written corner sequences.
module tb_program_counter_unit;

  logic        clk = 1'b0;
  logic        reset, fetch, decode, execute, commit, stopped, pc_enx, cond;
  logic [1:0]  pc_op;
  logic [15:0] target;
  logic [15:0] pc, link;
  logic        taken, seq_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic        cond;
    logic [15:0] target;
    logic        enx;
    logic [15:0] exp_pc;
    logic [15:0] exp_link;
    logic        exp_taken;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] link;
    logic        taken;
    logic        seq_err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[11];

  program_counter_unit #(.RESET_VECTOR(16'h0100)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .decode(decode), .execute(execute),
    .commit(commit), .stopped(stopped), .pc_enx(pc_enx), .pc_op(pc_op), .cond(cond),
    .target(target), .pc(pc), .link(link), .taken(taken), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 fetch, 1 decode, 2 execute, 3 commit
  task automatic strobe(input int which);
    fetch   = (which == 0);
    decode  = (which == 1);
    execute = (which == 2);
    commit  = (which == 3);
    tick();
    {fetch, decode, execute, commit} = 4'b0000;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 16'd1, 16'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, " pc"}, pc, e.pc);
    chk({tag, " link"}, link, e.link);
    chk({tag, " taken"}, {15'd0, taken}, {15'd0, e.taken});
    chk({tag, " seq_err"}, {15'd0, seq_err}, {15'd0, e.seq_err});
  endtask

  task automatic set_exec(input logic [1:0] op, input logic c, input logic [15:0] t);
    pc_op = op; cond = c; target = t;
  endtask

  // Garbage on the op inputs outside EXECUTE must be ignored.
  task automatic scramble_exec();
    pc_op = 2'b01; cond = 1'b1; target = 16'hDEAD;
  endtask

  task automatic run_instr(input string tag, input logic [1:0] op, input logic c,
                           input logic [15:0] t, input logic enx, input exp_t e);
    scramble_exec();
    strobe(0);
    strobe(1);
    set_exec(op, c, t);
    strobe(2);
    scramble_exec();
    pc_enx = enx;
    sb_q.push_back(e);
    strobe(3);
    pc_enx = 1'b0;
    compare_out(tag);
    tick();
    chk({tag, " taken_clears"}, {15'd0, taken}, 16'd0);
  endtask

  initial begin
    exp_t e;
    // op, cond, target, enx, exp_pc, exp_link, exp_taken (PC starts at 16'h0100)
    vecs[0]  = '{2'b00, 1'b0, 16'h0000, 1'b1, 16'h0101, 16'h0101, 1'b0};
    vecs[1]  = '{2'b01, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0102, 1'b1};
    vecs[2]  = '{2'b00, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{2'b01, 1'b1, 16'h0010, 1'b1, 16'h0010, 16'h0001, 1'b1};
    vecs[4]  = '{2'b10, 1'b1, 16'hFFFC, 1'b1, 16'h000C, 16'h0011, 1'b1};
    vecs[5]  = '{2'b01, 1'b1, 16'h0010, 1'b1, 16'h0010, 16'h000D, 1'b1};
    vecs[6]  = '{2'b10, 1'b0, 16'hFFFC, 1'b1, 16'h0011, 16'h0011, 1'b0};
    vecs[7]  = '{2'b01, 1'b1, 16'h1234, 1'b0, 16'h0011, 16'h0011, 1'b0};
    vecs[8]  = '{2'b11, 1'b1, 16'h5555, 1'b1, 16'h0011, 16'h0011, 1'b0};
    vecs[9]  = '{2'b01, 1'b0, 16'h1234, 1'b1, 16'h0012, 16'h0012, 1'b0};
    vecs[10] = '{2'b10, 1'b1, 16'h0005, 1'b1, 16'h0017, 16'h0013, 1'b1};

    reset = 1'b1; {fetch, decode, execute, commit} = 4'b0000;
    stopped = 1'b0; pc_enx = 1'b0; scramble_exec();
    tick(); tick();
    reset = 1'b0;
    chk("reset pc", pc, 16'h0100);
    chk("reset link", link, 16'h0000);
    chk("reset taken", {15'd0, taken}, 16'd0);
    chk("reset seq_err", {15'd0, seq_err}, 16'd0);

    foreach (vecs[i]) begin
      e = '{vecs[i].exp_pc, vecs[i].exp_link, vecs[i].exp_taken, 1'b0};
      run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].cond, vecs[i].target,
                vecs[i].enx, e);
    end

    // Stopped cycles in the middle of an instruction: no update, no error.
    strobe(0);
    strobe(1);
    stopped = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stopped%0d pc", k), pc, 16'h0017);
      chk($sformatf("stopped%0d seq_err", k), {15'd0, seq_err}, 16'd0);
    end
    stopped = 1'b0;
    set_exec(2'b01, 1'b1, 16'h0040);
    strobe(2);
    scramble_exec();
    pc_enx = 1'b1;
    sb_q.push_back('{16'h0040, 16'h0018, 1'b1, 1'b0});
    strobe(3);
    pc_enx = 1'b0;
    compare_out("after_stop");
    tick();

    // Commit straight after fetch: error, PC untouched, flag sticks.
    pc_enx = 1'b1;
    strobe(0);
    strobe(3);
    pc_enx = 1'b0;
    chk("seqerr flag", {15'd0, seq_err}, 16'd1);
    chk("seqerr pc", pc, 16'h0040);
    run_instr("post_err", 2'b00, 1'b0, 16'h0000, 1'b1, '{16'h0041, 16'h0041, 1'b0, 1'b1});

    // Reset coinciding with a valid commit discards the commit.
    strobe(0);
    strobe(1);
    set_exec(2'b01, 1'b1, 16'h1234);
    strobe(2);
    pc_enx = 1'b1; reset = 1'b1; commit = 1'b1;
    tick();
    reset = 1'b0; commit = 1'b0; pc_enx = 1'b0;
    chk("rstprio pc", pc, 16'h0100);
    chk("rstprio link", link, 16'h0000);
    chk("rstprio seq_err", {15'd0, seq_err}, 16'd0);
    tick();
    chk("rstprio taken", {15'd0, taken}, 16'd0);
    run_instr("post_rst", 2'b00, 1'b0, 16'h0000, 1'b1, '{16'h0101, 16'h0101, 1'b0, 1'b0});

    chk("scoreboard drained", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter_unit.md
PROGRAM_COUNTER_UNIT -- requirements
Module: programCounterUnit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports FETCH, DECODE, EXECUTE, COMMIT  input  1 each  one-hot phase strobes from the instruction phase decoder.
REQ-005 SHALL have port STOPPED  input  1  phase decoder idle/debug-stopped.
REQ-006 SHALL have port PC_ENX  input  1  PC update enable from the phase decoder.
REQ-007 SHALL have port PC_OP  input  2  update kind: 00 NEXT, 01 JUMP_ABS, 10 JUMP_REL, 11 HOLD.
REQ-008 SHALL have port COND  input  1  branch condition; a jump is taken only when COND=1.
REQ-009 SHALL have port TARGET  input  16  absolute target (JUMP_ABS) or signed two's-complement offset (JUMP_REL).
REQ-010 SHALL have port PC  output  16  current program counter, the instruction fetch address.
REQ-011 SHALL have port LINK  output  16  return address, PC+1 of the committed instruction.
REQ-012 SHALL have port TAKEN  output  1  one-cycle pulse: last commit loaded a jump target.
REQ-013 SHALL have port SEQ_ERR  output  1  sticky flag: phase strobes arrived out of order.

Function
REQ-014 SHALL be word-addressed; NEXT SHALL set PC <= PC+1, wrapping 16'hFFFF -> 16'h0000.
REQ-015 SHALL latch PC_OP, COND and TARGET on the clock edge where EXECUTE=1 (latched op); inputs at other phases SHALL be ignored.
REQ-016 SHALL update PC only on the edge where COMMIT=1 and PC_ENX=1, using the latched op; latency from COMMIT to new PC visible = 1 cycle.
REQ-017 SHALL compute JUMP_REL as PC + TARGET modulo 2^16 (16-bit add, carry discarded), PC being the address of the committed instruction.
REQ-018 SHALL treat a jump with latched COND=0 as NEXT, with TARGET ignored.
REQ-019 SHALL leave PC unchanged for HOLD, for COMMIT with PC_ENX=0, and while STOPPED=1.
REQ-020 SHALL set LINK <= PC+1 on every PC-updating commit, otherwise hold it.
REQ-021 SHALL assert TAKEN for exactly the cycle after a commit that loaded a jump target, else 0.
REQ-022 SHALL track phase order with FSM WAIT_F -> WAIT_D -> WAIT_E -> WAIT_C -> WAIT_F, advancing on the matching strobe.
REQ-023 SHALL hold the FSM state in cycles with no strobe, including while STOPPED.
REQ-024 SHALL set SEQ_ERR if any strobe other than the expected one is seen, or more than one strobe is high in a cycle; the FSM SHALL then go to WAIT_F and ignore the current COMMIT.
REQ-025 SHALL keep SEQ_ERR set until RESET.
REQ-026 SHALL clear the latched op to HOLD after each commit, so a repeated COMMIT without EXECUTE cannot re-apply a jump.

Reset
REQ-027 SHALL on RESET=1 at a clock edge set PC=RESET_VECTOR, LINK=16'h0000, TAKEN=0, SEQ_ERR=0, latched op=HOLD, FSM=WAIT_F.
REQ-028 SHALL give RESET priority over every simultaneous strobe, including a COMMIT in the same cycle, which is discarded.

Structure
REQ-029 SHALL take PC_OP encodings and FSM state encodings from the shared constants file.
REQ-030 SHALL isolate the phase-order FSM (REQ-022..025) in one sub-module, phaseSequenceChecker; PC datapath stays in the top.

Verification
REQ-031 SHALL check reset: RESET_VECTOR=16'h0100, RESET pulse -> PC=16'h0100, LINK=0, TAKEN=0, SEQ_ERR=0.
REQ-032 SHALL check NEXT with wrap: PC=16'hFFFF, full F/D/E/C cycle with PC_OP=00 and PC_ENX=1 -> PC=16'h0000, LINK=16'h0000.
REQ-033 SHALL check branches: PC=16'h0010, JUMP_REL, TARGET=16'hFFFC, COND=1 -> PC=16'h000C and one-cycle TAKEN; same sequence with COND=0 -> PC=16'h0011 and TAKEN=0.
REQ-034 SHALL check hold cases: JUMP_ABS TARGET=16'h1234 with PC_ENX=0 at COMMIT -> PC unchanged; three STOPPED cycles mid-sequence -> no update, no SEQ_ERR.
REQ-035 SHALL check sequencing errors: COMMIT directly after FETCH -> SEQ_ERR=1, PC unchanged, SEQ_ERR still 1 after a following valid cycle.
REQ-036 SHALL check reset priority: RESET asserted in the same cycle as a COMMIT -> PC=RESET_VECTOR.
